keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/col_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 138 +++++++++++++
 tb/tb_keypad_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared FSM state type, key map and small one-hot helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StHeld,
        StRelDb
    } state_e;

    // Indexed by {row, col}; entry 0 is row 0 / column 0.
    localparam logic [15:0][3:0] KeyMap = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KeyMap[{row, col}];
    endfunction

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] one_hot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] rotate_row(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer bringing the asynchronous column sense lines into the clk domain.
module col_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] async_col,
    output logic [3:0] sync_col
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_col;
            sync_q <= meta_q;
        end
    end

    assign sync_col = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce, one-cycle key_valid and key_held level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] r_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CNT);

    logic [3:0] col_s;

    col_sync u_col_sync (
        .clk      (clk),
        .reset    (reset),
        .async_col(col),
        .sync_col (col_s)
    );

    logic [DivW-1:0] div_q;
    logic            sample;

    assign sample = (div_q == DivLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (sample) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      row_q;
    logic [1:0]      col_q;
    logic [3:0]      r_sel_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_held_q;

    logic cap_bit;
    logic cap_match;

    // During HELD/REL_DB only the captured column matters; extra closed keys are ignored.
    assign cap_bit   = col_s[col_q];
    assign cap_match = (col_s == (4'b0001 << col_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StScan;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            r_sel_q     <= 4'b0001;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            unique case (state_q)
                StScan: begin
                    if (sample) begin
                        if (is_one_hot(col_s)) begin
                            row_q   <= one_hot_index(r_sel_q);
                            col_q   <= one_hot_index(col_s);
                            cnt_q   <= CntW'(1);
                            state_q <= StPressDb;
                        end else begin
                            r_sel_q <= rotate_row(r_sel_q);
                        end
                    end
                end
                StPressDb: begin
                    if (cnt_q == CntDone) begin
                        key_code_q  <= key_lookup(row_q, col_q);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StHeld;
                    end else if (sample) begin
                        if (cap_match) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end else begin
                            cnt_q   <= '0;
                            r_sel_q <= rotate_row(r_sel_q);
                            state_q <= StScan;
                        end
                    end
                end
                StHeld: begin
                    if (sample && !cap_bit) begin
                        cnt_q   <= CntW'(1);
                        state_q <= StRelDb;
                    end
                end
                StRelDb: begin
                    if (cnt_q == CntDone) begin
                        key_held_q <= 1'b0;
                        r_sel_q    <= rotate_row(r_sel_q);
                        cnt_q      <= '0;
                        state_q    <= StScan;
                    end else if (sample) begin
                        if (!cap_bit) begin
                            cnt_q <= cnt_q + CntW'(1);
                        end else begin
                            cnt_q   <= '0;
                            state_q <= StHeld;
                        end
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= StScan;
                end
            endcase
        end
    end

    assign r_sel     = r_sel_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: vector table plus scoreboard of expected key codes.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] col = 4'b0000;
    logic [3:0] r_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .col      (col),
        .r_sel    (r_sel),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] next_row(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // Scoreboard: every key_valid pulse must match the oldest expected code.
    always @(negedge clk) begin
        if (!reset && key_valid === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                check("key_valid while none expected", 32'(key_valid), 32'd0);
            end else begin
                exp_code = exp_q.pop_front();
                check("scoreboard key_code", 32'(key_code), 32'(exp_code));
                check("key_held at pulse", 32'(key_held), 32'd1);
            end
        end
    end

    // Returns #1 after the edge on which r_sel switches into target.
    task automatic wait_row(input logic [3:0] target);
        int n;
        n = 0;
        while (r_sel === target && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        while (r_sel !== target && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait for row", 32'(r_sel), 32'(target));
    endtask

    task automatic wait_held(input logic val, input int limit, output int n);
        n = 0;
        while (key_held !== val && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] pattern;
        logic       press;
        logic [3:0] code;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen0;
        logic dropped;

        vecs[0] = '{4'b0100, 4'b0010, 1'b1, 4'h8};
        vecs[1] = '{4'b0001, 4'b0001, 1'b1, 4'h1};
        vecs[2] = '{4'b0010, 4'b1000, 1'b1, 4'hB};
        vecs[3] = '{4'b1000, 4'b0001, 1'b1, 4'hE};
        vecs[4] = '{4'b1000, 4'b0010, 1'b1, 4'h0};
        vecs[5] = '{4'b0001, 4'b1001, 1'b0, 4'h0};
        vecs[6] = '{4'b1000, 4'b1000, 1'b1, 4'hD};
        vecs[7] = '{4'b0100, 4'b0000, 1'b0, 4'h0};
        vecs[8] = '{4'b0010, 4'b0110, 1'b0, 4'h0};
        vecs[9] = '{4'b1000, 4'b0100, 1'b1, 4'hF};

        // Reset state and idle scanning.
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset r_sel", 32'(r_sel), 32'h1);
        check("reset key_code", 32'(key_code), 32'h0);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset key_held", 32'(key_held), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            check($sformatf("idle r_sel k=%0d", k), 32'(r_sel), 32'(4'b0001 << ((k / 4) % 4)));
            check($sformatf("idle key_code k=%0d", k), 32'(key_code), 32'h0);
        end
        check("idle no pulses", 32'(valid_seen), 32'd0);

        // Single-sample glitch: captured, then dropped at the next sample.
        wait_row(4'b0001);
        seen0 = valid_seen;
        col = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        col = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("glitch r_sel frozen", 32'(r_sel), 32'h1);
        @(posedge clk); #1;
        check("glitch r_sel advance", 32'(r_sel), 32'h2);
        repeat (4) @(posedge clk);
        #1;
        check("glitch scan resumes", 32'(r_sel), 32'h4);
        check("glitch key_held", 32'(key_held), 32'h0);
        check("glitch no pulse", 32'(valid_seen - seen0), 32'd0);

        for (int i = 0; i < NV; i++) begin
            wait_row(vecs[i].row);
            seen0 = valid_seen;
            col = vecs[i].pattern;
            if (vecs[i].press) begin
                exp_q.push_back(vecs[i].code);
                wait_held(1'b1, 40, n);
                check($sformatf("vec%0d press latency", i), 32'(n), 32'd13);
                repeat (12) @(posedge clk);
                #1;
                check($sformatf("vec%0d r_sel frozen", i), 32'(r_sel), 32'(vecs[i].row));
                check($sformatf("vec%0d held", i), 32'(key_held), 32'd1);
                col = 4'b0000;
                wait_held(1'b0, 40, n);
                check($sformatf("vec%0d release latency %0d in 12..15", i, n),
                      32'(n >= 12 && n <= 15), 32'd1);
                check($sformatf("vec%0d r_sel after release", i), 32'(r_sel),
                      32'(next_row(vecs[i].row)));
                check($sformatf("vec%0d key_code holds", i), 32'(key_code), 32'(vecs[i].code));
                check($sformatf("vec%0d pulse count", i), 32'(valid_seen - seen0), 32'd1);
            end else begin
                repeat (24) @(posedge clk);
                #1;
                check($sformatf("vec%0d ignored held", i), 32'(key_held), 32'd0);
                check($sformatf("vec%0d ignored pulses", i), 32'(valid_seen - seen0), 32'd0);
                col = 4'b0000;
            end
        end

        // Release bounce: one clear sample, then the key closes again.
        wait_row(4'b0010);
        seen0 = valid_seen;
        col = 4'b0100;
        exp_q.push_back(4'h6);
        wait_held(1'b1, 40, n);
        check("bounce press latency", 32'(n), 32'd13);
        col = 4'b0000;
        repeat (4) @(posedge clk);
        #1;
        col = 4'b0100;
        dropped = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            if (key_held !== 1'b1) dropped = 1'b1;
        end
        check("bounce held stays", 32'(dropped), 32'd0);
        check("bounce r_sel frozen", 32'(r_sel), 32'h2);
        check("bounce pulse count", 32'(valid_seen - seen0), 32'd1);
        col = 4'b0000;
        wait_held(1'b0, 40, n);
        check("bounce final release", 32'(key_held), 32'd0);

        // Reset while HELD, key kept closed: fresh debounce on row 0 yields key 2.
        wait_row(4'b0100);
        col = 4'b0010;
        exp_q.push_back(4'h8);
        wait_held(1'b1, 40, n);
        check("pre-reset press latency", 32'(n), 32'd13);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset r_sel", 32'(r_sel), 32'h1);
        check("async reset key_code", 32'(key_code), 32'h0);
        check("async reset key_valid", 32'(key_valid), 32'h0);
        check("async reset key_held", 32'(key_held), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen0 = valid_seen;
        exp_q.push_back(4'h2);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (key_valid === 1'b1) begin
                n = k;
                break;
            end
        end
        check("post-reset first pulse cycle", 32'(n), 32'd13);
        col = 4'b0000;
        wait_held(1'b0, 40, n);
        check("post-reset release", 32'(key_held), 32'd0);
        check("post-reset pulse count", 32'(valid_seen - seen0), 32'd1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
